operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage directly upstream of the 8-bit ALU: holds the 8x8 register file and reads two sources.
//  Selects register or immediate for operand B and registers alu_input_a/alu_input_b/alu_opcode for the ALU.
//  Write-back bypass plus a per-register pending scoreboard interlock RAW hazards.
//  Valid/ready handshake on both sides; stalls are counted for performance debug.
// PARAMETERS
//  NREGS      8   number of architectural registers (address width = $clog2(NREGS) = 3)
//  DW         8   data width of registers and ALU operands
//  STALL_W    16  width of saturating stall counter
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  in_valid     in   1   upstream instruction present
//  in_ready     out  1   stage accepts instruction this cycle
//  in_rs_a      in   3   source register A
//  in_rs_b      in   3   source register B
//  in_rd        in   3   destination register
//  in_wr_en     in   1   instruction writes in_rd
//  in_opcode    in   3   ALU opcode, passed through
//  in_use_imm   in   1   1: operand B = in_imm, rs_b ignored
//  in_imm       in   8   immediate
//  alu_input_a  out  8   registered operand A to ALU
//  alu_input_b  out  8   registered operand B to ALU
//  alu_opcode   out  3   registered opcode to ALU
//  out_rd       out  3   registered destination
//  out_wr_en    out  1   registered write enable
//  out_valid    out  1   output register holds a valid instruction
//  out_ready    in   1   downstream consumes output this cycle
//  wb_en        in   1   write-back strobe (ALU result retiring)
//  wb_addr      in   3   write-back register
//  wb_data      in   8   write-back data
//  stall_count  out  16  saturating count of cycles with in_valid && !in_ready
// BEHAVIOUR
//  Reset (reset_n=0, async): all registers, pending bits, outputs, stall_count = 0; out_valid=0.
//  Register r0 reads 0 always; writes to r0 ignored; r0 never pending.
//  Read: src value = (wb_en && wb_addr==src && src!=0) ? wb_data : regs[src] (same-cycle bypass).
//  Write: on posedge, if wb_en && wb_addr!=0, regs[wb_addr] <= wb_data.
//  Scoreboard pending[NREGS]: set on accept when in_wr_en && in_rd!=0; cleared on wb_en at wb_addr.
//   Same-cycle set and clear of the same register: set wins.
//  hazard = (pending[rs_a] && !(wb_en && wb_addr==rs_a)) ||
//   (!in_use_imm && pending[rs_b] && !(wb_en && wb_addr==rs_b)); r0 never hazards.
//  in_ready = !hazard && (!out_valid || out_ready). accept = in_valid && in_ready.
//  Output register: on accept load alu_input_a, alu_input_b (imm or reg), alu_opcode, out_rd, out_wr_en;
//   out_valid<=1. Else if out_ready, out_valid<=0 (data regs keep value). Else hold all.
//  Latency: 1 cycle accept -> out_valid. Throughput 1/cycle with no hazard and out_ready=1.
//  Outputs stable while out_valid && !out_ready.
//  stall_count increments each cycle in_valid && !in_ready; saturates at 16'hFFFF, no wrap.
//  Reset mid-operation: in-flight output dropped, pending cleared, register contents zeroed.
//  wb_en to a non-pending register is legal: writes data, pending stays 0.
// TESTING
//  T1 reset: reset_n=0 with clk idle -> out_valid=0, alu_input_a/b=0, stall_count=0 immediately.
//  T2 accept: wb r3=8'h12, then in rs_a=3, imm=8'h05, use_imm=1, op=3'b001 -> next cycle a=12, b=05, out_valid=1.
//  T3 bypass: wb_en r2=8'hA5 same cycle as accept reading rs_a=2 -> alu_input_a=8'hA5.
//  T4 hazard: accept rd=4 wr_en=1, next instr reads r4 -> in_ready=0, stall_count increments until wb r4;
//   on the wb cycle the instruction is accepted with the wb_data value.
//  T5 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs held, in_ready=0, no instr lost or duplicated.
//  T6 r0/saturation: wb r0=8'hFF -> reads of r0 give 0; force 65540 stall cycles -> stall_count=16'hFFFF.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x8 register file, write-back bypass and RAW scoreboard,
// registered operand/opcode hand-off to the ALU with valid/ready on both sides.
module operand_fetch #(
   parameter int NREGS   = 8,
   parameter int DW      = 8,
   parameter int STALL_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [$clog2(NREGS)-1:0] in_rs_a,
   input  logic [$clog2(NREGS)-1:0] in_rs_b,
   input  logic [$clog2(NREGS)-1:0] in_rd,
   input  logic                     in_wr_en,
   input  logic [2:0]               in_opcode,
   input  logic                     in_use_imm,
   input  logic [DW-1:0]            in_imm,
   output logic [DW-1:0]            alu_input_a,
   output logic [DW-1:0]            alu_input_b,
   output logic [2:0]               alu_opcode,
   output logic [$clog2(NREGS)-1:0] out_rd,
   output logic                     out_wr_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     wb_en,
   input  logic [$clog2(NREGS)-1:0] wb_addr,
   input  logic [DW-1:0]            wb_data,
   output logic [STALL_W-1:0]       stall_count
);

   logic [DW-1:0]      r_regs [NREGS];
   logic [NREGS-1:0]   r_pend;
   logic [STALL_W-1:0] r_stall;

   logic               w_hz_a;
   logic               w_hz_b;
   logic               w_accept;
   logic [DW-1:0]      w_rd_a;
   logic [DW-1:0]      w_rd_b;
   logic [DW-1:0]      w_op_b;
   logic [NREGS-1:0]   w_set;
   logic [NREGS-1:0]   w_clr;

   // r0 is hard-wired to zero and is never marked pending
   always_comb begin
      w_rd_a = r_regs[in_rs_a];
      w_rd_b = r_regs[in_rs_b];
      if (wb_en && wb_addr == in_rs_a)
         w_rd_a = wb_data;
      if (wb_en && wb_addr == in_rs_b)
         w_rd_b = wb_data;
      if (in_rs_a == '0)
         w_rd_a = '0;
      if (in_rs_b == '0)
         w_rd_b = '0;
   end

   always_comb begin
      w_hz_a = r_pend[in_rs_a] && !(wb_en && wb_addr == in_rs_a);
      w_hz_b = !in_use_imm && r_pend[in_rs_b]
               && !(wb_en && wb_addr == in_rs_b);
   end

   assign w_op_b      = in_use_imm ? in_imm : w_rd_b;
   assign in_ready    = !(w_hz_a || w_hz_b) && (!out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign stall_count = r_stall;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_accept && in_wr_en && in_rd != '0)
         w_set[in_rd] = 1'b1;
      if (wb_en)
         w_clr[wb_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else if (wb_en && wb_addr != '0) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   // a new claim on a register outranks a retiring write to it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_pend <= '0;
      else
         r_pend <= (r_pend & ~w_clr) | w_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_input_a <= '0;
         alu_input_b <= '0;
         alu_opcode  <= '0;
         out_rd      <= '0;
         out_wr_en   <= 1'b0;
         out_valid   <= 1'b0;
      end else if (w_accept) begin
         alu_input_a <= w_rd_a;
         alu_input_b <= w_op_b;
         alu_opcode  <= in_opcode;
         out_rd      <= in_rd;
         out_wr_en   <= in_wr_en;
         out_valid   <= 1'b1;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_stall <= '0;
      else if (in_valid && !in_ready && r_stall != '1)
         r_stall <= r_stall + STALL_W'(1);
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written hazard,
// backpressure, saturation and reset sequences, then random vs a reference model.
module tb_operand_fetch;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_rs_a;
   logic [2:0] in_rs_b;
   logic [2:0] in_rd;
   logic       in_wr_en;
   logic [2:0] in_opcode;
   logic       in_use_imm;
   logic [7:0] in_imm;
   logic [7:0] alu_input_a;
   logic [7:0] alu_input_b;
   logic [2:0] alu_opcode;
   logic [2:0] out_rd;
   logic       out_wr_en;
   logic       out_valid;
   logic       out_ready;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic [15:0] stall_count;

   int checks = 0;
   int errors = 0;

   operand_fetch dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs_a     (in_rs_a),
      .in_rs_b     (in_rs_b),
      .in_rd       (in_rd),
      .in_wr_en    (in_wr_en),
      .in_opcode   (in_opcode),
      .in_use_imm  (in_use_imm),
      .in_imm      (in_imm),
      .alu_input_a (alu_input_a),
      .alu_input_b (alu_input_b),
      .alu_opcode  (alu_opcode),
      .out_rd      (out_rd),
      .out_wr_en   (out_wr_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wbe;
      logic [2:0] wba;
      logic [7:0] wbd;
      logic       iv;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [2:0] rd;
      logic       we;
      logic [2:0] op;
      logic       ui;
      logic [7:0] imm;
      logic       ordy;
      logic       e_rdy;
      logic       e_ov;
      logic [7:0] e_a;
      logic [7:0] e_b;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic setin(input logic iv, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [2:0] rd,
                        input logic we, input logic [2:0] op,
                        input logic ui, input logic [7:0] imm,
                        input logic ordy);
      in_valid   = iv;
      in_rs_a    = ra;
      in_rs_b    = rb;
      in_rd      = rd;
      in_wr_en   = we;
      in_opcode  = op;
      in_use_imm = ui;
      in_imm     = imm;
      out_ready  = ordy;
   endtask

   task automatic setwb(input logic e, input logic [2:0] a,
                        input logic [7:0] d);
      wb_en   = e;
      wb_addr = a;
      wb_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model state
   logic [7:0] m_regs [8];
   logic       m_pend [8];
   logic [7:0] m_a, m_b;
   logic [2:0] m_op, m_rd;
   logic       m_we, m_ov;
   int         m_stall;

   function automatic logic [7:0] m_read(input logic [2:0] s);
      if (s == 3'd0) return 8'h00;
      if (wb_en && wb_addr == s) return wb_data;
      return m_regs[s];
   endfunction

   function automatic logic m_busy(input logic [2:0] s);
      if (s == 3'd0) return 1'b0;
      return m_pend[s] && !(wb_en && wb_addr == s);
   endfunction

   initial begin
      logic e_rdy;
      logic acc;
      logic [7:0] ra_v, rb_v;

      reset_n = 1'b1;
      setin(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
      setwb(1'b0, 3'd0, 8'h00);

      tbl[0] = '{1'b1, 3'd3, 8'h12, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0,
                 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd1,
                 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h12, 8'h05};
      tbl[2] = '{1'b1, 3'd2, 8'hA5, 1'b1, 3'd2, 3'd3, 3'd0, 1'b0, 3'd2,
                 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h12};
      tbl[3] = '{1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd3,
                 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
      tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0,
                 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
      tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd0, 1'b0, 3'd4,
                 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5};

      // async reset with no clock edge in between
      #2 reset_n = 1'b0;
      #1;
      chk("rst ov", 32'(out_valid), 32'd0);
      chk("rst a", 32'(alu_input_a), 32'd0);
      chk("rst b", 32'(alu_input_b), 32'd0);
      chk("rst stall", 32'(stall_count), 32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         setwb(tbl[i].wbe, tbl[i].wba, tbl[i].wbd);
         setin(tbl[i].iv, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].we,
               tbl[i].op, tbl[i].ui, tbl[i].imm, tbl[i].ordy);
         #1;
         chk($sformatf("v%0d rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         tick();
         chk($sformatf("v%0d ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("v%0d a", i), 32'(alu_input_a), 32'(tbl[i].e_a));
         chk($sformatf("v%0d b", i), 32'(alu_input_b), 32'(tbl[i].e_b));
      end
      setwb(1'b0, 3'd0, 8'h00);
      chk("tbl stall", 32'(stall_count), 32'd0);

      // hazard on r4 until its write-back arrives
      setin(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 3'd0, 1'b1, 8'h00, 1'b1);
      tick();
      chk("hz prod rd", 32'(out_rd), 32'd4);
      setin(1'b1, 3'd4, 3'd0, 3'd5, 1'b0, 3'd5, 1'b1, 8'h09, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         #1;
         chk($sformatf("hz rdy%0d", k), 32'(in_ready), 32'd0);
         tick();
         chk($sformatf("hz stall%0d", k), 32'(stall_count), 32'(k));
      end
      chk("hz drained", 32'(out_valid), 32'd0);
      setwb(1'b1, 3'd4, 8'h77);
      #1;
      chk("hz wb rdy", 32'(in_ready), 32'd1);
      tick();
      setwb(1'b0, 3'd0, 8'h00);
      chk("hz a", 32'(alu_input_a), 32'h77);
      chk("hz b", 32'(alu_input_b), 32'h09);
      chk("hz ov", 32'(out_valid), 32'd1);
      chk("hz stall", 32'(stall_count), 32'd3);

      // backpressure
      setin(1'b1, 3'd3, 3'd0, 3'd1, 1'b0, 3'd6, 1'b1, 8'h11, 1'b1);
      tick();
      chk("bp x a", 32'(alu_input_a), 32'h12);
      setin(1'b1, 3'd2, 3'd0, 3'd2, 1'b0, 3'd7, 1'b1, 8'h22, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         #1;
         chk($sformatf("bp rdy%0d", k), 32'(in_ready), 32'd0);
         tick();
         chk($sformatf("bp hold%0d", k),
             {out_valid, alu_opcode, alu_input_a, alu_input_b},
             {1'b1, 3'd6, 8'h12, 8'h11});
      end
      chk("bp stall", 32'(stall_count), 32'd6);
      out_ready = 1'b1;
      #1;
      chk("bp rel rdy", 32'(in_ready), 32'd1);
      tick();
      chk("bp y", {out_valid, alu_opcode, alu_input_a, alu_input_b},
          {1'b1, 3'd7, 8'hA5, 8'h22});
      in_valid = 1'b0;
      tick();
      chk("bp no dup", 32'(out_valid), 32'd0);

      // stall saturation; leaves r4 pending for the reset check
      setin(1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 3'd1, 1'b1, 8'h01, 1'b1);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 65540; k++) begin
         @(posedge clk);
      end
      #1;
      chk("sat", 32'(stall_count), 32'hFFFF);
      chk("sat ov", 32'(out_valid), 32'd1);

      // reset mid-operation
      reset_n = 1'b0;
      #1;
      chk("mrst ov", 32'(out_valid), 32'd0);
      chk("mrst stall", 32'(stall_count), 32'd0);
      chk("mrst a", 32'(alu_input_a), 32'd0);
      tick();
      reset_n = 1'b1;
      setin(1'b1, 3'd4, 3'd3, 3'd0, 1'b0, 3'd2, 1'b0, 8'h00, 1'b1);
      #1;
      chk("mrst pend", 32'(in_ready), 32'd1);
      tick();
      chk("mrst regs", {alu_input_a, alu_input_b}, 16'h0000);

      // random traffic against the model
      reset_n = 1'b0;
      setin(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = 8'h00;
         m_pend[i] = 1'b0;
      end
      m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_we = 0; m_ov = 0;
      m_stall = 0;
      for (int c = 0; c < 400; c++) begin
         setwb($urandom_range(0, 2) == 0, 3'($urandom), 8'($urandom));
         setin($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
               3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
               8'($urandom), $urandom_range(0, 3) != 0);
         #1;
         e_rdy = !(m_busy(in_rs_a) || (!in_use_imm && m_busy(in_rs_b)))
                 && (!m_ov || out_ready);
         chk($sformatf("rnd%0d rdy", c), 32'(in_ready), 32'(e_rdy));
         acc  = in_valid && e_rdy;
         ra_v = m_read(in_rs_a);
         rb_v = in_use_imm ? in_imm : m_read(in_rs_b);
         if (in_valid && !e_rdy && m_stall < 65535) m_stall++;
         if (acc) begin
            m_a = ra_v; m_b = rb_v; m_op = in_opcode;
            m_rd = in_rd; m_we = in_wr_en; m_ov = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
         if (wb_en) m_pend[wb_addr] = 1'b0;
         if (acc && in_wr_en && in_rd != 3'd0) m_pend[in_rd] = 1'b1;
         if (wb_en && wb_addr != 3'd0) m_regs[wb_addr] = wb_data;
         tick();
         chk($sformatf("rnd%0d out", c),
             {out_valid, alu_input_a, alu_input_b, alu_opcode,
              out_rd, out_wr_en},
             {m_ov, m_a, m_b, m_op, m_rd, m_we});
         chk($sformatf("rnd%0d stall", c), 32'(stall_count),
             32'(m_stall));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
